// File: rtl/seq_mul_6x6.sv
// Sequential unsigned shift-and-add multiplier. One partial-product addition
// per clock through a ripple chain of half/full adder cells, valid/ready on both sides.
module seq_mul_6x6 #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;

    function automatic logic [1:0] half_adder(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    assign addend = acc_q[0] ? mcand_q : '0;

    // Upper accumulator half plus gated multiplicand; the carry lands in sum[WIDTH].
    always_comb begin : adder_chain
        logic carry;
        sum = '0;
        {carry, sum[0]} = half_adder(acc_q[WIDTH], addend[0]);
        for (int i = 1; i < WIDTH; i++) begin
            {carry, sum[i]} = full_adder(acc_q[WIDTH+i], addend[i], carry);
        end
        sum[WIDTH] = carry;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    product_d = {sum, acc_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all registers are plain flops (no memory arrays), so every one of them is reset.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Handshake outputs decode the registered state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mul_6x6.sv
// Self-checking bench for seq_mul_6x6: transaction-level model checked every
// cycle, in-order scoreboard, and directed vectors with literal expectations.
module tb_seq_mul_6x6;

    localparam int WIDTH = 6;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] product;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    bit cmp_en = 1'b0;

    // Model: cycles left in the calculation, result-held flag, expected product.
    int m_left  = 0;
    bit m_valid = 1'b0;
    int m_prod  = 0;

    int          exp_q[$];
    logic [11:0] got_q[$];
    longint      got_t[$];

    seq_mul_6x6 #(.WIDTH(6), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model advanced on each edge from the bench's own view of the protocol.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(product);
                got_t.push_back($time);
                if (exp_q.size() == 0) check("sb_unexpected_output", product, 32'hFFFF_FFFF);
                else check("sb_product", product, exp_q.pop_front());
            end
            if (m_valid) begin
                if (out_ready) m_valid = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_valid = 1'b1;
            end else if (in_valid) begin
                m_prod = int'(a) * int'(b);
                m_left = WIDTH;
                exp_q.push_back(m_prod);
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("in_ready", in_ready, 32'(!m_valid && m_left == 0));
            check("out_valid", out_valid, 32'(m_valid));
            check("busy", busy, 32'(m_valid || m_left != 0));
            if (m_valid) check("product_hold", product, m_prod);
        end
    end

    // Caller is at a negedge; returns at a negedge with the result consumed.
    task automatic one_pair(input int x, input int y, input int exp_p, input string tag);
        int t0;
        int w;
        int g0;
        g0 = got_q.size();
        w  = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check({tag, "_ready"}, in_ready, 1);
        a = 6'(x); b = 6'(y); in_valid = 1'b1; out_ready = 1'b1; t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        check({tag, "_latency"}, cyc - t0, 7);
        @(negedge clk);
        check({tag, "_count"}, got_q.size() - g0, 1);
        if (got_q.size() > g0) check({tag, "_product"}, got_q[g0], exp_p);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    int bb_a[3] = '{10, 63, 33};
    int bb_b[3] = '{10, 1, 62};
    int bb_p[3] = '{100, 63, 2046};

    initial begin
        int n0;
        int g0;
        int w;
        int idx;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_product", product, 0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        one_pair(63, 63, 3969, "max");
        one_pair(0, 45, 0, "zero_a");
        one_pair(45, 0, 0, "zero_b");
        one_pair(1, 45, 45, "one_a");

        // Downstream stall with a competing input that must be ignored.
        n0 = n_acc;
        g0 = got_q.size();
        a = 6'd37; b = 6'd22; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        check("stall_valid", out_valid, 1);
        a = 6'd5; b = 6'd5; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_product", product, 814);
        end
        check("stall_no_accept", n_acc - n0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        w = 0;
        while (n_acc - n0 < 2 && w < 10) begin @(negedge clk); w++; end
        in_valid = 1'b0;
        check("stall_second_accept", n_acc - n0, 2);
        out_ready = 1'b1;
        w = 0;
        while (got_q.size() - g0 < 2 && w < 30) begin @(negedge clk); w++; end
        check("stall_count", got_q.size() - g0, 2);
        if (got_q.size() >= g0 + 2) begin
            check("stall_first", got_q[g0], 814);
            check("stall_second", got_q[g0+1], 25);
        end

        // Back-to-back stream with in_valid held high.
        @(negedge clk);
        n0 = n_acc;
        g0 = got_q.size();
        w  = 0;
        while (n_acc - n0 < 3 && w < 100) begin
            idx = n_acc - n0;
            a = 6'(bb_a[idx]); b = 6'(bb_b[idx]); in_valid = 1'b1;
            @(negedge clk);
            w++;
        end
        in_valid = 1'b0;
        w = 0;
        while (got_q.size() - g0 < 3 && w < 50) begin @(negedge clk); w++; end
        check("b2b_count", got_q.size() - g0, 3);
        if (got_q.size() >= g0 + 3) begin
            for (int i = 0; i < 3; i++) check("b2b_product", got_q[g0+i], bb_p[i]);
            check("b2b_spacing_1", 32'((got_t[g0+1] - got_t[g0]) / 10), 8);
            check("b2b_spacing_2", 32'((got_t[g0+2] - got_t[g0+1]) / 10), 8);
        end

        // Reset in the middle of a calculation.
        @(negedge clk);
        g0 = got_q.size();
        a = 6'd50; b = 6'd50; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_product", product, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_stale", got_q.size() - g0, 0);
        one_pair(2, 3, 6, "after_rst");
        check("after_rst_total", got_q.size() - g0, 1);

        // Exhaustive sweep with random downstream stalls.
        @(negedge clk);
        n0 = n_acc;
        g0 = got_q.size();
        w  = 0;
        while (n_acc - n0 < 4096 && w < 80000) begin
            idx = n_acc - n0;
            a = 6'((idx >> 6) & 63);
            b = 6'(idx & 63);
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 200) begin @(negedge clk); w++; end
        check("sweep_accepted", n_acc - n0, 4096);
        check("sweep_count", got_q.size() - g0, 4096);
        check("sweep_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
